cmp_search_ctrl: RTL and testbench
==================================

Name: cmp_search_ctrl

Overview:
Sequencer that time-shares one 5-bit XOR equality comparator to search a small register table for a key. Software/upstream logic loads table entries, pulses start with a key, and the block scans entries one per cycle through the single comparator. It reports the lowest matching index, or a miss. It sits in front of the ALU comparator path as its scheduler.

Parameters:
WIDTH, 5, bit width of key and table entries
DEPTH, 8, number of table entries (power of two, >=2)
IDXW, 3, index width, must equal log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  table write strobe; honoured only when busy=0
wr_addr  input  IDXW  table write index
wr_data  input  WIDTH  table write data; write also sets valid[wr_addr]
start  input  1  begin search; honoured only when busy=0
key  input  WIDTH  search key, sampled on the edge that accepts start
busy  output  1  high while a search is in progress (SCAN and DONE states)
done  output  1  one-cycle pulse, search finished
hit  output  1  1 = match found; held until next accepted start
hit_idx  output  IDXW  lowest matching index; 0 on miss; held like hit

Behaviour:
- One clock (clk), synchronous active-high reset (reset); all outputs registered.
- Reset: state=IDLE, busy=0, done=0, hit=0, hit_idx=0, all valid bits=0, table data=0, scan index=0, latched key=0. Reset mid-scan aborts immediately with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE: start=1 -> latch key, idx<=0, hit<=0, hit_idx<=0, busy<=1, go SCAN. Otherwise stay.
- SCAN: compare latched key vs table[idx] through comparator (ne=0 means equal). match = (ne==0) & valid[idx].
  - match -> hit<=1, hit_idx<=idx, go DONE.
  - no match, idx==DEPTH-1 -> hit<=0, hit_idx<=0, go DONE.
  - else idx<=idx+1 (no wrap; the last index always exits).
- DONE: done=1 for exactly this cycle, busy still 1; next edge -> IDLE, busy<=0, done<=0.
- Latency: start accepted at edge E0; entry i compared in cycle i after E0; done high for one cycle, i+2 cycles after E0 on hit at i; DEPTH+1 cycles after E0 on miss.
- First match wins; later duplicates ignored. Invalid entries never match, even if data equals key.
- wr_en while busy=1: ignored, table unchanged. start while busy=1: ignored, no queueing.
- wr_en and start on the same IDLE edge: both accepted; the write commits at that edge and the scan sees the new entry.
- Key changes after acceptance do not affect the running search.
- Comparator is purely combinational; no extra pipeline stage.

Decomposition:
- Shared package/header: WIDTH, DEPTH, IDXW defaults; FSM state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
- Sub-module cmp_xor_eq: WIDTH-bit bitwise XOR of a and b, OR-reduced to output ne (0 = equal). Instantiated once inside cmp_search_ctrl.
- Table, valid bits, FSM and index counter live in cmp_search_ctrl.

Test Plan:
- Reset then start key=5'b00100 with empty table -> no hit; done pulses exactly DEPTH+1=9 cycles after start edge; hit=0, hit_idx=0; busy low the cycle after done.
- Write [2]=5'b00100, [5]=5'b00100, start key=5'b00100 -> done 4 cycles after start edge; hit=1, hit_idx=2 (lowest index wins).
- Write [0]=5'b00010, start key=5'b00000 -> miss; write [7]=5'b00000, repeat -> hit=1, hit_idx=7; done 9 cycles after start edge.
- During a scan, pulse wr_en to [3]=key and pulse start -> both ignored; result and timing identical to a run with no disturbance.
- Same-edge wr_en [0]=5'b00001 and start key=5'b00001 in IDLE -> hit=1, hit_idx=0; done 2 cycles after start edge.
- Assert reset in cycle 3 of a scan -> next cycle busy=0, done=0, hit=0, all valid bits cleared; a subsequent search of a previously written value misses.

Source files
------------

// File: rtl/cmp_search_ctrl_pkg.sv
// Shared defaults and FSM encoding for the table-search sequencer.
package cmp_search_ctrl_pkg;

   localparam int unsigned DEF_WIDTH = 5;
   localparam int unsigned DEF_DEPTH = 8;
   localparam int unsigned DEF_IDXW  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cmp_xor_eq.sv
// Combinational equality comparator: ne is 0 when a and b are bit-identical.
module cmp_xor_eq
   import cmp_search_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ne
);

   assign ne = |(a ^ b);

endmodule

// File: rtl/cmp_search_ctrl.sv
// Scans a small register table one entry per cycle through a single shared
// comparator and reports the lowest valid index whose data equals the key.
module cmp_search_ctrl
   import cmp_search_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned IDXW  = DEF_IDXW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDXW-1:0]  wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic [WIDTH-1:0] key,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic [IDXW-1:0]  hit_idx
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tbl_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [IDXW-1:0]  idx_q;
   logic [WIDTH-1:0] key_q;

   logic             busy_d, done_d, hit_d;
   logic [IDXW-1:0]  hit_idx_d;
   logic             ne, match, last, accept, wr_ok;

   assign accept = start & ~busy & (state_q == ST_IDLE);
   assign wr_ok  = wr_en & ~busy & (state_q == ST_IDLE);
   assign last   = (idx_q == IDXW'(DEPTH - 1));
   assign match  = ~ne & valid_q[idx_q];

   cmp_xor_eq #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a  (key_q),
      .b  (tbl_q[idx_q]),
      .ne (ne)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_SCAN;
         ST_SCAN: if (match || last) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are flopped off the current state, so done lands the cycle after
   // DONE and busy stays up through that pulse.
   always_comb begin
      busy_d    = busy;
      done_d    = (state_q == ST_DONE);
      hit_d     = hit;
      hit_idx_d = hit_idx;
      unique case (state_q)
         ST_IDLE: begin
            busy_d = accept;
            if (accept) begin
               hit_d     = 1'b0;
               hit_idx_d = '0;
            end
         end
         ST_SCAN: begin
            busy_d = 1'b1;
            if (match) begin
               hit_d     = 1'b1;
               hit_idx_d = idx_q;
            end else if (last) begin
               hit_d     = 1'b0;
               hit_idx_d = '0;
            end
         end
         ST_DONE: busy_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         hit     <= 1'b0;
         hit_idx <= '0;
      end else begin
         busy    <= busy_d;
         done    <= done_d;
         hit     <= hit_d;
         hit_idx <= hit_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl_q[i] <= '0;
         end
         valid_q <= '0;
         idx_q   <= '0;
         key_q   <= '0;
      end else begin
         if (wr_ok) begin
            tbl_q[wr_addr]   <= wr_data;
            valid_q[wr_addr] <= 1'b1;
         end
         if (accept) begin
            key_q <= key;
            idx_q <= '0;
         end else if ((state_q == ST_SCAN) && !match && !last) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Scoreboard bench: the driver pushes expected results from a table model,
// a monitor pops and compares each time done pulses.
module tb_cmp_search_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [4:0] wr_data;
   logic       start;
   logic [4:0] key;
   logic       busy, done, hit;
   logic [2:0] hit_idx;

   always #5 clk = ~clk;

   cmp_search_ctrl u_dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .key     (key),
      .busy    (busy),
      .done    (done),
      .hit     (hit),
      .hit_idx (hit_idx)
   );

   typedef struct {
      bit hit;
      int idx;
      int lat;
      int start_cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] m_data [DEPTH];
   bit         m_valid [DEPTH];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_data[i]  = '0;
         m_valid[i] = 1'b0;
      end
   endtask

   // All driver tasks are entered and left at a falling edge.
   task automatic wr(input int a, input logic [4:0] d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = d;
      m_data[a]  = d;
      m_valid[a] = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic search(input logic [4:0] k, input bit same_wr, input int a,
                         input logic [4:0] d);
      exp_t e;
      int   first;
      start = 1'b1;
      key   = k;
      if (same_wr) begin
         wr_en      = 1'b1;
         wr_addr    = 3'(a);
         wr_data    = d;
         m_data[a]  = d;
         m_valid[a] = 1'b1;
      end
      first = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (first < 0 && m_valid[i] && m_data[i] == k) first = i;
      end
      e.hit       = (first >= 0);
      e.idx       = e.hit ? first : 0;
      e.lat       = e.hit ? first + 2 : DEPTH + 1;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      key   = 5'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor
   initial begin
      bit prev_done = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (prev_done) check("busy_after_done", int'(busy), 0);
         if (done) begin
            check("busy_during_done", int'(busy), 1);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("hit", int'(hit), int'(e.hit));
               check("hit_idx", int'(hit_idx), e.idx);
               check("latency", cyc - e.start_cyc, e.lat);
            end
         end
         prev_done = done;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      key     = '0;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_hit", int'(hit), 0);
      check("rst_hit_idx", int'(hit_idx), 0);

      // Empty table misses
      search(5'b00100, 1'b0, 0, '0);
      wait_done();

      // Lowest duplicate wins
      wr(2, 5'b00100);
      wr(5, 5'b00100);
      search(5'b00100, 1'b0, 0, '0);
      wait_done();

      // Miss, then hit at the last index
      wr(0, 5'b00010);
      search(5'b00000, 1'b0, 0, '0);
      wait_done();
      wr(7, 5'b00000);
      search(5'b00000, 1'b0, 0, '0);
      wait_done();

      // Write and start during a scan are both dropped
      wr(6, 5'h15);
      search(5'h15, 1'b0, 0, '0);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 3'd3;
      wr_data = 5'h15;
      start   = 1'b1;
      key     = 5'h00;
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      wait_done();
      search(5'h15, 1'b0, 0, '0);
      wait_done();

      // Same-edge write and start
      search(5'b00001, 1'b1, 0, 5'b00001);
      wait_done();

      // Randomised traffic over a narrow data range to get frequent hits
      for (int it = 0; it < 30; it++) begin
         int nwr;
         nwr = $urandom_range(0, 3);
         for (int w = 0; w < nwr; w++) begin
            wr($urandom_range(0, DEPTH - 1), 5'($urandom_range(0, 3)));
         end
         search(5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, DEPTH - 1), 5'($urandom_range(0, 3)));
         wait_done();
      end

      // Reset mid-scan aborts and clears the table
      wr(7, 5'h09);
      search(5'h09, 1'b0, 0, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      model_clear();
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_hit", int'(hit), 0);
      repeat (12) @(negedge clk);
      search(5'h09, 1'b0, 0, '0);
      wait_done();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
